complex_dot_accumulator: RTL and testbench
==========================================

// Module: complex_dot_accumulator
// PURPOSE
//  Downstream of the conjugate complex multiplier. Sums VEC_LEN complex FP32 products conj(A)*B into one complex
//  inner product. Pipelined FP adders are fed back through ADD_LAT round-robin partial sums, reduced once the
//  vector ends. The result is held on a valid/ready output.
// PARAMETERS
//  VEC_LEN  16  elements per vector; >=1
//  ADD_LAT  4   adder_subtractor pipeline depth in ce-cycles; must match that module exactly; >=1
//  CNT_W    $clog2(VEC_LEN+1)  element counter width (derived, not for override)
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   asynchronous reset, active-high
//  ce         in   1   global clock enable; low = whole block frozen
//  in_valid   in   1   in_data valid
//  in_ready   out  1   block accepts in_data this cycle
//  in_data    in   64  {real[63:32], imag[31:0]}, IEEE-754 single each
//  out_valid  out  1   out_data holds a finished dot product
//  out_ready  in   1   consumer takes out_data
//  out_data   out  64  {real[63:32], imag[31:0]} complex sum
//  busy       out  1   high from first accept until output handshake
//  nan_flag   out  1   only with CDOT_NAN_FLAG_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async): state=IDLE; in_ready/out_valid/busy/nan_flag=0; out_data=0; partials, counters, adder pipeline=0.
//   in_ready rises on the first clk edge after rst deassert with ce=1.
//  Handshake counts only when ce=1: accept = in_valid&in_ready&ce; take = out_valid&out_ready&ce.
//   in_valid while in_ready=0 is ignored; upstream holds data. out_ready while out_valid=0 has no effect.
//  FSM: IDLE -> ACCUM -> DRAIN -> REDUCE -> HOLD -> IDLE.
//   IDLE: in_ready=1; first accept -> ACCUM, busy=1, count=1.
//   ACCUM: in_ready=1; element k (0-based) issues partial[k mod ADD_LAT] + in_data; the sum is written back to the
//     same slot ADD_LAT cycles later. Input gaps are allowed: a slot is never reread before its write-back.
//     The VEC_LEN-th accept drops in_ready the next cycle -> DRAIN. If VEC_LEN==1, IDLE goes straight to DRAIN.
//   DRAIN: ADD_LAT cycles to retire in-flight sums -> REDUCE.
//   REDUCE: acc=partial[0]. For j=1..ADD_LAT-1, serially issue acc+partial[j] and wait ADD_LAT per add.
//     Unused slots (VEC_LEN<ADD_LAT) stay +0.0. ADD_LAT==1 skips REDUCE. Then -> HOLD.
//   HOLD: out_valid=1; out_data stable until take. take -> IDLE: partials cleared, busy=0, out_valid=0 next cycle.
//  Latency (ce=1): last accept to out_valid = ADD_LAT + (ADD_LAT-1)*ADD_LAT + 1 cycles; 17 for ADD_LAT=4.
//  Arithmetic: one adder_subtractor for real and one for imag, both add-only. They are shared between ACCUM and
//   REDUCE; the FSM guarantees no overlap. No rounding or normalisation beyond what the adders do.
//   Summation order is fixed and deterministic.
//  ce=0: FSM, counters, partials and adder pipeline freeze; outputs hold their values.
//  rst mid-vector or mid-REDUCE: work is discarded, the block returns to the reset state, no partial output.
// CONFIGURATION
//  CDOT_NAN_FLAG_EN defined: nan_flag is set when any accepted real or imag field has exponent==8'hFF (NaN/Inf).
//   It is sticky for the vector, valid with out_valid, and cleared on take or rst.
//  Undefined: no nan_flag port and no detect logic; datapath behaviour identical.
// STRUCTURE
//  Shared package complex_pkg: FP32_W=32, CPLX_W=64, FP32_ZERO, FP32_EXP_MSB/LSB, re()/im() field-extract
//   helpers, FSM state encoding.
//  One sub-module, cdot_partial_bank: ADD_LAT-entry complex register file plus an ADD_LAT-deep slot-index/valid
//   delay line that steers adder results back to their slot; clear and ce inputs.
//  adder_subtractor instantiated twice (real, imag); no new arithmetic.
// TESTING
//  1 VEC_LEN=16, 16x {1.0,2.0} (0x3F800000_40000000) back-to-back -> out_data 0x41800000_42000000 (16.0, 32.0),
//    out_valid exactly 17 cycles after last accept.
//  2 16 elements alternating real +1.0/-1.0 (0xBF800000), imag 0.5 (0x3F000000) -> 0x00000000_41000000.
//  3 Repeat test 1 with random in_valid gaps and ce low for 1-5 cycles -> identical result; no accept while ce=0.
//  4 Hold out_ready=0 for 10 cycles in HOLD -> out_data stable, in_ready=0. Release -> in_ready=1 next cycle;
//    a second vector gives a clean result with no carry-over.
//  5 Assert rst after 7 accepts -> all outputs 0 immediately. Then a full vector of {2.0,0} -> 0x42000000_00000000.
//  6 CDOT_NAN_FLAG_EN: one element real=0x7FC00000 -> nan_flag=1 with out_valid, 0 after take. Undefined: no port.

Source files
------------

// File: rtl/complex_pkg.sv
// Shared definitions for the complex dot-product accumulator.
// Holds the FP32/complex widths, the FP32 exponent field position, helpers
// that split a packed complex word into its real and imaginary halves, and
// the accumulator FSM state encoding.
package complex_pkg;

  localparam int FP32_W       = 32;
  localparam int CPLX_W       = 64;
  localparam int FP32_EXP_MSB = 30;
  localparam int FP32_EXP_LSB = 23;
  localparam logic [FP32_W-1:0] FP32_ZERO = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DRAIN,
    ST_REDUCE,
    ST_HOLD
  } cdotState_t;

  // Complex words are packed {real, imag}.
  function automatic logic [FP32_W-1:0] re(input logic [CPLX_W-1:0] c);
    return c[CPLX_W-1:FP32_W];
  endfunction

  function automatic logic [FP32_W-1:0] im(input logic [CPLX_W-1:0] c);
    return c[FP32_W-1:0];
  endfunction

  // All-ones exponent marks NaN or infinity.
  function automatic logic isNanInf(input logic [FP32_W-1:0] x);
    return x[FP32_EXP_MSB:FP32_EXP_LSB] == 8'hFF;
  endfunction

endpackage

// File: rtl/adder_subtractor.sv
// Pipelined IEEE-754 single-precision adder/subtractor.
// Ports:
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   i_ce       clock enable; low freezes the whole pipeline
//   i_sub      1 = compute a - b, 0 = a + b
//   i_a, i_b   FP32 operands
//   o_result   FP32 result, LATENCY enabled cycles after the operands
// Round-to-nearest-even; subnormal inputs and results are flushed to zero.
module adder_subtractor #(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_ce,
  input  logic        i_sub,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_result
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  function automatic logic [31:0] fpAdd(input logic [31:0] a, input logic [31:0] b);
    logic        sL, sS;
    logic [7:0]  eL, d;
    logic [26:0] mL, mS, mSh;
    logic [27:0] sum;
    logic [24:0] mant;
    logic        sticky, roundUp;
    int          eRes, lead, shift;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      if ((a[30:23] == 8'hFF && a[22:0] != 23'd0) || (b[30:23] == 8'hFF && b[22:0] != 23'd0))
        return QNAN;
      if (a[30:23] == 8'hFF && b[30:23] == 8'hFF && a[31] != b[31])
        return QNAN;
      return (a[30:23] == 8'hFF) ? a : b;
    end
    if (a[30:23] == 8'd0 && b[30:23] == 8'd0) return {a[31] & b[31], 31'd0};
    if (a[30:23] == 8'd0) return b;
    if (b[30:23] == 8'd0) return a;
    // Order operands so the larger magnitude sets sign and exponent.
    if (a[30:0] >= b[30:0]) begin
      sL = a[31]; eL = a[30:23]; mL = {1'b1, a[22:0], 3'b000};
      sS = b[31]; mS = {1'b1, b[22:0], 3'b000}; d = a[30:23] - b[30:23];
    end else begin
      sL = b[31]; eL = b[30:23]; mL = {1'b1, b[22:0], 3'b000};
      sS = a[31]; mS = {1'b1, a[22:0], 3'b000}; d = b[30:23] - a[30:23];
    end
    // Align the smaller operand, folding shifted-out bits into a sticky bit.
    if (d >= 8'd27) begin
      mSh = 27'd1;
    end else begin
      mSh    = mS >> d;
      sticky = |(mS & ((27'd1 << d) - 27'd1));
      mSh[0] = mSh[0] | sticky;
    end
    eRes = int'(eL);
    if (sL == sS) begin
      sum = {1'b0, mL} + {1'b0, mSh};
      if (sum[27]) begin
        sum  = {1'b0, sum[27:2], sum[1] | sum[0]};
        eRes = eRes + 1;
      end
    end else begin
      sum = {1'b0, mL} - {1'b0, mSh};
      if (sum == 28'd0) return 32'd0;
      lead = 0;
      for (int i = 0; i < 27; i++) if (sum[i]) lead = i;
      shift = 26 - lead;
      sum   = sum << shift;
      eRes  = eRes - shift;
    end
    roundUp = sum[2] & (sum[1] | sum[0] | sum[3]);
    mant    = {1'b0, sum[26:3]} + {24'd0, roundUp};
    if (mant[24]) begin
      mant = mant >> 1;
      eRes = eRes + 1;
    end
    if (eRes >= 255) return {sL, 8'hFF, 23'd0};
    if (eRes <= 0) return {sL, 31'd0};
    return {sL, eRes[7:0], mant[22:0]};
  endfunction

  logic [31:0] w_bEff;
  logic [31:0] r_pipe [LATENCY];

  assign w_bEff   = i_sub ? {~i_b[31], i_b[30:0]} : i_b;
  assign o_result = r_pipe[LATENCY-1];

  // The full sum is formed in the first stage; later stages only delay it so
  // that the result appears exactly LATENCY enabled cycles after issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) r_pipe[i] <= '0;
    end else if (i_ce) begin
      r_pipe[0] <= fpAdd(i_a, w_bEff);
      for (int i = 1; i < LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

endmodule

// File: rtl/cdot_partial_bank.sv
// Round-robin partial-sum register file for the complex dot accumulator.
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   i_ce           clock enable; low freezes slots and delay line
//   i_clear        zero every slot and drop any pending write-back
//   i_issueValid   an accumulate add is issued this cycle into slot i_issueIdx
//   i_issueIdx     slot the issued add will write back to
//   i_wbData       adder output, aligned with the end of the delay line
//   i_rdIdx        slot to read
//   o_rdData       slot contents, bypassed with a same-cycle write-back
//   o_slot0        slot 0 contents
module cdot_partial_bank
  import complex_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ce,
  input  logic              i_clear,
  input  logic              i_issueValid,
  input  logic [IDX_W-1:0]  i_issueIdx,
  input  logic [IDX_W-1:0]  i_rdIdx,
  input  logic [CPLX_W-1:0] i_wbData,
  output logic [CPLX_W-1:0] o_rdData,
  output logic [CPLX_W-1:0] o_slot0
);

  logic [CPLX_W-1:0] r_slot     [DEPTH];
  logic              r_dlyValid [DEPTH];
  logic [IDX_W-1:0]  r_dlyIdx   [DEPTH];
  logic              w_wbValid;
  logic [IDX_W-1:0]  w_wbIdx;

  assign w_wbValid = r_dlyValid[DEPTH-1];
  assign w_wbIdx   = r_dlyIdx[DEPTH-1];

  // A back-to-back reuse of a slot reads it in the very cycle its previous
  // sum emerges from the adder, so the write-back value is forwarded.
  assign o_rdData = (w_wbValid && w_wbIdx == i_rdIdx) ? i_wbData : r_slot[i_rdIdx];
  assign o_slot0  = r_slot[0];

  // The slot-index delay line runs in lockstep with the adder pipeline so
  // each result lands in the slot that produced its operand.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_slot[i]     <= {FP32_ZERO, FP32_ZERO};
        r_dlyValid[i] <= 1'b0;
        r_dlyIdx[i]   <= '0;
      end
    end else if (i_ce) begin
      if (i_clear) begin
        for (int i = 0; i < DEPTH; i++) begin
          r_slot[i]     <= {FP32_ZERO, FP32_ZERO};
          r_dlyValid[i] <= 1'b0;
        end
      end else begin
        r_dlyValid[0] <= i_issueValid;
        r_dlyIdx[0]   <= i_issueIdx;
        for (int i = 1; i < DEPTH; i++) begin
          r_dlyValid[i] <= r_dlyValid[i-1];
          r_dlyIdx[i]   <= r_dlyIdx[i-1];
        end
        if (w_wbValid) r_slot[w_wbIdx] <= i_wbData;
      end
    end
  end

endmodule

// File: rtl/complex_dot_accumulator.sv
// Complex FP32 inner-product accumulator.
// Sums VEC_LEN complex products into ADD_LAT round-robin partial sums through
// shared pipelined adders, reduces the partials serially, and presents the
// result on a valid/ready output.
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   ce                   global clock enable; low freezes the block
//   in_valid/in_ready    input handshake, in_data = {real, imag} FP32
//   out_valid/out_ready  output handshake, out_data = {real, imag} FP32
//   busy                 high from first accept until the output is taken
//   nan_flag             present only when CDOT_NAN_FLAG_EN is defined:
//                        sticky NaN/Inf seen in any accepted field
module complex_dot_accumulator
  import complex_pkg::*;
#(
  parameter  int VEC_LEN = 16,
  parameter  int ADD_LAT = 4,
  localparam int CNT_W   = $clog2(VEC_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CPLX_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CPLX_W-1:0] out_data,
  output logic              busy
`ifdef CDOT_NAN_FLAG_EN
  ,
  output logic              nan_flag
`endif
);

  localparam int IDX_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
  localparam int RED_W = $clog2(ADD_LAT + 1);

  cdotState_t        r_state;
  logic              r_inReady, r_outValid, r_busy;
  logic [CPLX_W-1:0] r_outData;
  logic [CNT_W-1:0]  r_count;
  logic [IDX_W-1:0]  r_slot, r_wait;
  logic [RED_W-1:0]  r_redSlot;

  logic              w_accept, w_take, w_inReduce;
  logic [IDX_W-1:0]  w_rdIdx, w_slotNext;
  logic [CPLX_W-1:0] w_rdData, w_slot0, w_sum, w_redAcc, w_opA, w_opB;

  assign w_accept   = in_valid & r_inReady & ce;
  assign w_take     = r_outValid & out_ready & ce;
  assign w_inReduce = (r_state == ST_REDUCE);
  assign w_slotNext = (r_slot == IDX_W'(ADD_LAT - 1)) ? '0 : r_slot + IDX_W'(1);

  // During REDUCE the running total starts as slot 0 and afterwards is the
  // adder output of the previous step; the same value is the final result.
  assign w_rdIdx  = w_inReduce ? r_redSlot[IDX_W-1:0] : r_slot;
  assign w_redAcc = (r_redSlot == RED_W'(1)) ? w_slot0 : w_sum;
  assign w_opA    = w_inReduce ? w_redAcc : w_rdData;
  assign w_opB    = w_inReduce ? w_rdData : in_data;

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign out_data  = r_outData;
  assign busy      = r_busy;

  cdot_partial_bank #(.DEPTH(ADD_LAT)) u_bank (
    .clk          (clk),
    .rst          (rst),
    .i_ce         (ce),
    .i_clear      (w_take),
    .i_issueValid (w_accept),
    .i_issueIdx   (r_slot),
    .i_rdIdx      (w_rdIdx),
    .i_wbData     (w_sum),
    .o_rdData     (w_rdData),
    .o_slot0      (w_slot0)
  );

  adder_subtractor #(.LATENCY(ADD_LAT)) u_addRe (
    .clk      (clk),
    .rst      (rst),
    .i_ce     (ce),
    .i_sub    (1'b0),
    .i_a      (re(w_opA)),
    .i_b      (re(w_opB)),
    .o_result (w_sum[CPLX_W-1:FP32_W])
  );

  adder_subtractor #(.LATENCY(ADD_LAT)) u_addIm (
    .clk      (clk),
    .rst      (rst),
    .i_ce     (ce),
    .i_sub    (1'b0),
    .i_a      (im(w_opA)),
    .i_b      (im(w_opB)),
    .o_result (w_sum[FP32_W-1:0])
  );

  // Control FSM. r_wait counts the DRAIN cycles and then the per-add wait
  // inside REDUCE; r_redSlot is the next partial to fold in, and reaching
  // ADD_LAT means the last reduction add has emerged from the adder.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_inReady  <= 1'b0;
      r_outValid <= 1'b0;
      r_busy     <= 1'b0;
      r_outData  <= '0;
      r_count    <= '0;
      r_slot     <= '0;
      r_wait     <= '0;
      r_redSlot  <= '0;
    end else if (ce) begin
      case (r_state)
        ST_IDLE: begin
          r_inReady <= 1'b1;
          if (w_accept) begin
            r_busy  <= 1'b1;
            r_count <= CNT_W'(1);
            r_slot  <= w_slotNext;
            r_wait  <= '0;
            if (VEC_LEN == 1) begin
              r_inReady <= 1'b0;
              r_state   <= ST_DRAIN;
            end else begin
              r_state <= ST_ACCUM;
            end
          end
        end
        ST_ACCUM: begin
          if (w_accept) begin
            r_count <= r_count + CNT_W'(1);
            r_slot  <= w_slotNext;
            if (r_count == CNT_W'(VEC_LEN - 1)) begin
              r_inReady <= 1'b0;
              r_wait    <= '0;
              r_state   <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (r_wait == IDX_W'(ADD_LAT - 1)) begin
            r_wait    <= '0;
            r_redSlot <= RED_W'(1);
            r_state   <= ST_REDUCE;
          end else begin
            r_wait <= r_wait + IDX_W'(1);
          end
        end
        ST_REDUCE: begin
          if (r_redSlot == RED_W'(ADD_LAT)) begin
            r_outData  <= w_redAcc;
            r_outValid <= 1'b1;
            r_state    <= ST_HOLD;
          end else if (r_wait == IDX_W'(ADD_LAT - 1)) begin
            r_wait    <= '0;
            r_redSlot <= r_redSlot + RED_W'(1);
          end else begin
            r_wait <= r_wait + IDX_W'(1);
          end
        end
        ST_HOLD: begin
          if (w_take) begin
            r_outValid <= 1'b0;
            r_busy     <= 1'b0;
            r_inReady  <= 1'b1;
            r_count    <= '0;
            r_slot     <= '0;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef CDOT_NAN_FLAG_EN
  logic r_nanFlag;
  assign nan_flag = r_nanFlag;

  // Sticky for the whole vector; cleared when the result is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nanFlag <= 1'b0;
    end else if (ce) begin
      if (w_take) r_nanFlag <= 1'b0;
      else if (w_accept && (isNanInf(re(in_data)) || isNanInf(im(in_data)))) r_nanFlag <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_complex_dot_accumulator.sv
// Directed testbench for complex_dot_accumulator (VEC_LEN=16, ADD_LAT=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_complex_dot_accumulator;

  logic        clock = 1'b0;
  logic        reset;
  logic        ce;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        busy;
`ifdef CDOT_NAN_FLAG_EN
  logic        nan_flag;
`endif

  int errorCount = 0;
  int checkCount = 0;
  int cycleCount = 0;
  int lastAcceptCycle = 0;
  int latency;

  complex_dot_accumulator dut (
    .clk       (clock),
    .rst       (reset),
    .ce        (ce),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef CDOT_NAN_FLAG_EN
    ,
    .nan_flag  (nan_flag)
`endif
  );

  // 10 ns clock.
  always #5 clock = ~clock;

  // Free-running edge counter used for latency measurement.
  always @(posedge clock) cycleCount <= cycleCount + 1;

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=0x%016h expected=0x%016h", tag, observed, expected);
    end
  endtask

  // Present one element, optionally after an idle gap and with ce held low
  // for a few cycles first; returns on the falling edge after the accept.
  task automatic applyStimulus(input logic [63:0] data, input int gap, input int ceLow, input logic expBusy);
    int waited = 0;
    repeat (gap) @(negedge clock);
    in_valid = 1'b1;
    in_data  = data;
    if (ceLow > 0) begin
      ce = 1'b0;
      repeat (ceLow) @(negedge clock);
      checkOutput("ceFreezeBusy", {63'd0, busy}, {63'd0, expBusy});
      ce = 1'b1;
    end
    while (!(in_ready && ce) && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    if (!(in_ready && ce)) checkOutput("acceptTimeout", {63'd0, in_ready}, 64'd1);
    @(negedge clock);
    lastAcceptCycle = cycleCount;
    in_valid = 1'b0;
  endtask

  task automatic waitOutput(input int budget, output int lat);
    int n = 0;
    while (!out_valid && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (!out_valid) checkOutput("outValidTimeout", {63'd0, out_valid}, 64'd1);
    lat = cycleCount - lastAcceptCycle;
  endtask

  task automatic takeOutput();
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    ce        = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clock);

    checkOutput("resetInReady",  {63'd0, in_ready},  64'd0);
    checkOutput("resetOutValid", {63'd0, out_valid}, 64'd0);
    checkOutput("resetBusy",     {63'd0, busy},      64'd0);
    checkOutput("resetOutData",  out_data,           64'd0);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("inReadyAfterReset", {63'd0, in_ready}, 64'd1);

    // Test 1: 16 x {1.0, 2.0} back-to-back.
    for (int i = 0; i < 16; i++) applyStimulus(64'h3F800000_40000000, 0, 0, i > 0);
    waitOutput(100, latency);
    checkOutput("t1Latency", 64'(latency), 64'd17);
    checkOutput("t1Data",    out_data, 64'h41800000_42000000);
    checkOutput("t1Busy",    {63'd0, busy},     64'd1);
    checkOutput("t1InReady", {63'd0, in_ready}, 64'd0);
    takeOutput();
    checkOutput("t1OutValidAfterTake", {63'd0, out_valid}, 64'd0);
    checkOutput("t1BusyAfterTake",     {63'd0, busy},      64'd0);

    // Test 2: real alternating +1.0/-1.0, imag 0.5.
    for (int i = 0; i < 16; i++)
      applyStimulus((i % 2 == 0) ? 64'h3F800000_3F000000 : 64'hBF800000_3F000000, 0, 0, i > 0);
    waitOutput(100, latency);
    checkOutput("t2Data", out_data, 64'h00000000_41000000);
    takeOutput();

    // Test 3: test 1 with random gaps and ce-low stretches.
    for (int i = 0; i < 16; i++)
      applyStimulus(64'h3F800000_40000000, int'($urandom_range(0, 3)),
                    (i % 3 == 0) ? int'($urandom_range(1, 5)) : 0, i > 0);
    waitOutput(100, latency);
    checkOutput("t3Data", out_data, 64'h41800000_42000000);
    ce = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("t3CeLowOutValid", {63'd0, out_valid}, 64'd1);
    checkOutput("t3CeLowData",     out_data, 64'h41800000_42000000);
    out_ready = 1'b1;
    @(negedge clock);
    checkOutput("t3NoTakeWhileCeLow", {63'd0, out_valid}, 64'd1);
    out_ready = 1'b0;
    ce = 1'b1;
    takeOutput();
    checkOutput("t3OutValidAfterTake", {63'd0, out_valid}, 64'd0);

    // Test 4: back-pressure in HOLD, then a clean second vector.
    for (int i = 0; i < 16; i++) applyStimulus(64'h3F800000_40000000, 0, 0, i > 0);
    waitOutput(100, latency);
    for (int i = 0; i < 10; i++) begin
      checkOutput("t4HoldData",    out_data, 64'h41800000_42000000);
      checkOutput("t4HoldInReady", {63'd0, in_ready}, 64'd0);
      @(negedge clock);
    end
    takeOutput();
    checkOutput("t4InReadyAfterTake", {63'd0, in_ready},  64'd1);
    checkOutput("t4OutValidCleared",  {63'd0, out_valid}, 64'd0);
    for (int i = 0; i < 16; i++) applyStimulus(64'h3F000000_BF800000, 0, 0, i > 0);
    waitOutput(100, latency);
    checkOutput("t4SecondData", out_data, 64'h41000000_C1800000);
    takeOutput();

    // Test 5: reset after 7 accepts, then a full vector of {2.0, 0}.
    for (int i = 0; i < 7; i++) applyStimulus(64'h3F800000_40000000, 0, 0, i > 0);
    reset = 1'b1;
    #1;
    checkOutput("t5RstInReady",  {63'd0, in_ready},  64'd0);
    checkOutput("t5RstOutValid", {63'd0, out_valid}, 64'd0);
    checkOutput("t5RstBusy",     {63'd0, busy},      64'd0);
    checkOutput("t5RstOutData",  out_data,           64'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) applyStimulus(64'h40000000_00000000, 0, 0, i > 0);
    waitOutput(100, latency);
    checkOutput("t5Data", out_data, 64'h42000000_00000000);
    takeOutput();

`ifdef CDOT_NAN_FLAG_EN
    // Test 6: a NaN real field raises the sticky flag.
    for (int i = 0; i < 16; i++)
      applyStimulus((i == 5) ? 64'h7FC00000_40000000 : 64'h3F800000_40000000, 0, 0, i > 0);
    waitOutput(100, latency);
    checkOutput("t6NanFlagSet", {63'd0, nan_flag}, 64'd1);
    takeOutput();
    checkOutput("t6NanFlagCleared", {63'd0, nan_flag}, 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
